// File: rtl/cache_pkg.sv
// Shared types and constants for the L2 downstream memory responder.
package cache_pkg;

  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam int STAT_W = 12;
  // Address width carried through the request FIFO; bounds the responder's ADDR_W.
  localparam int REQ_ADDR_W = 48;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_RESP
  } state_t;

  typedef struct packed {
    logic [7:0]            op;
    logic [REQ_ADDR_W-1:0] addr;
  } req_t;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] value);
    return (&value) ? value : value + STAT_W'(1);
  endfunction

endpackage

// File: rtl/cache_req_fifo.sv
// Request buffer: show-ahead synchronous FIFO of req_t, extra pointer bit separates full from empty.
module cache_req_fifo
  import cache_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  req_t din,
  output req_t head,
  output logic full,
  output logic empty
);

  localparam int PTR_W = $clog2(DEPTH);

  req_t             mem [DEPTH];
  logic [PTR_W:0]   wr_ptr_reg;
  logic [PTR_W:0]   rd_ptr_reg;

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                 (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);
  assign head  = mem[rd_ptr_reg[PTR_W-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push && !full)
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop && !empty)
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  // Storage is not reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (push && !full)
      mem[wr_ptr_reg[PTR_W-1:0]] <= din;
  end

endmodule

// File: rtl/cache_mem_responder.sv
// Main-memory responder below the L2: buffered requests, fixed latency, read responses, op counters.
// Optional MEM_WRITE_ACK_EN: writes also produce a response (non-posted).
module cache_mem_responder
  import cache_pkg::*;
#(
  parameter int ADDR_W      = 48,
  parameter int BLOCK_BYTES = 64,
  parameter int LATENCY     = 4,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [7:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [ADDR_W-1:0] resp_addr,
  output logic [7:0]        resp_op,
  output logic              busy,
  output logic [STAT_W-1:0] mem_reads,
  output logic [STAT_W-1:0] mem_writes,
  output logic [STAT_W-1:0] mem_errors
);

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
`ifdef MEM_WRITE_ACK_EN
  localparam bit ACK_WRITES = 1'b1;
`else
  localparam bit ACK_WRITES = 1'b0;
`endif

  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic              accept;
  logic              op_read;
  logic              op_write;
  req_t              push_req;
  req_t              head_req;
  state_t            state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [7:0]        cur_op_reg;
  logic [ADDR_W-1:0] cur_addr_reg;
  logic [2:0]        stat_inc;
  logic [2:0][STAT_W-1:0] stat;

  assign req_ready = !fifo_full;
  assign accept    = req_valid && !fifo_full;
  assign op_read   = (req_op == OP_READ);
  assign op_write  = (req_op == OP_WRITE);
  assign push      = accept && (op_read || op_write);
  assign pop       = (state_reg == ST_IDLE) && !fifo_empty;
  assign busy      = !fifo_empty || (state_reg != ST_IDLE);

  assign push_req.op   = req_op;
  assign push_req.addr = REQ_ADDR_W'(req_addr & ~ADDR_W'(BLOCK_BYTES - 1));

  cache_req_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (push_req),
    .head  (head_req),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Counter order: reads, writes, errors. Illegal ops are counted but never queued.
  assign stat_inc = {accept && !op_read && !op_write, accept && op_write, accept && op_read};

  for (genvar gi = 0; gi < 3; gi++) begin : g_stat
    logic [STAT_W-1:0] cnt_stat_reg;
    always_ff @(posedge clk or posedge reset) begin
      if (reset)
        cnt_stat_reg <= '0;
      else if (stat_inc[gi])
        cnt_stat_reg <= sat_inc(cnt_stat_reg);
    end
    assign stat[gi] = cnt_stat_reg;
  end

  assign mem_reads  = stat[0];
  assign mem_writes = stat[1];
  assign mem_errors = stat[2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= '0;
      cur_op_reg   <= '0;
      cur_addr_reg <= '0;
      resp_valid   <= 1'b0;
      resp_addr    <= '0;
      resp_op      <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (!fifo_empty) begin
            cur_op_reg   <= head_req.op;
            cur_addr_reg <= ADDR_W'(head_req.addr);
            cnt_reg      <= CNT_W'(LATENCY - 1);
            state_reg    <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - 1'b1;
          end else if (cur_op_reg == OP_READ || ACK_WRITES) begin
            resp_valid <= 1'b1;
            resp_addr  <= cur_addr_reg;
            resp_op    <= cur_op_reg;
            state_reg  <= ST_RESP;
          end else begin
            state_reg <= ST_IDLE;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state_reg  <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_mem_responder.sv
// Self-checking bench for cache_mem_responder: scoreboard of expected responses filled on acceptance.
module tb_cache_mem_responder;
  import cache_pkg::*;

  localparam int ADDR_W      = 48;
  localparam int BLOCK_BYTES = 64;
  localparam int LATENCY     = 4;
  localparam int FIFO_DEPTH  = 4;
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(BLOCK_BYTES - 1);
`ifdef MEM_WRITE_ACK_EN
  localparam bit ACK_W = 1'b1;
`else
  localparam bit ACK_W = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic [7:0]        req_op;
  logic [ADDR_W-1:0] req_addr;
  logic              resp_valid;
  logic              resp_ready;
  logic [ADDR_W-1:0] resp_addr;
  logic [7:0]        resp_op;
  logic              busy;
  logic [11:0]       mem_reads;
  logic [11:0]       mem_writes;
  logic [11:0]       mem_errors;

  int passed = 0;
  int total  = 0;
  int exp_reads = 0, exp_writes = 0, exp_errors = 0;
  logic [ADDR_W-1:0] exp_addr_q[$];
  logic [7:0]        exp_op_q[$];

  always #5 clk = ~clk;

  cache_mem_responder #(
    .ADDR_W      (ADDR_W),
    .BLOCK_BYTES (BLOCK_BYTES),
    .LATENCY     (LATENCY),
    .FIFO_DEPTH  (FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_addr  (resp_addr),
    .resp_op    (resp_op),
    .busy       (busy),
    .mem_reads  (mem_reads),
    .mem_writes (mem_writes),
    .mem_errors (mem_errors)
  );

  task automatic model_count(input logic [7:0] op);
    if (op == OP_READ) begin
      if (exp_reads < 4095) exp_reads++;
    end else if (op == OP_WRITE) begin
      if (exp_writes < 4095) exp_writes++;
    end else begin
      if (exp_errors < 4095) exp_errors++;
    end
  endtask

  // Drives one request from posedge+1 and returns at posedge+1 after the accepting edge.
  task automatic send(input logic [7:0] op, input logic [ADDR_W-1:0] addr, input bit track);
    bit done = 1'b0;
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    for (int c = 0; c < 200 && !done; c++) begin
      if (req_ready) done = 1'b1;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    if (!done) begin
      total++;
      $display("FAIL send_timeout op=%h addr=%h not accepted within 200 cycles", op, addr);
    end else begin
      model_count(op);
      if (track && (op == OP_READ || (ACK_W && op == OP_WRITE))) begin
        exp_addr_q.push_back(addr & LINE_MASK);
        exp_op_q.push_back(op);
      end
    end
  endtask

  // Waits for resp_valid; consumes it when resp_ready is high.
  task automatic get_resp(input int budget, output bit got, output int cycles,
                          output logic [ADDR_W-1:0] a, output logic [7:0] o);
    got = 1'b0; cycles = 0; a = '0; o = '0;
    for (int c = 1; c <= budget && !got; c++) begin
      @(posedge clk); #1;
      if (resp_valid) begin
        got = 1'b1; cycles = c; a = resp_addr; o = resp_op;
      end
    end
    if (got && resp_ready) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; req_valid = 1'b0; req_op = '0; req_addr = '0; resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (resp_valid !== 1'b0) $display("FAIL reset_resp_valid got=%b want=0", resp_valid); else passed++;
    total++; if (resp_addr !== '0) $display("FAIL reset_resp_addr got=%h want=0", resp_addr); else passed++;
    total++; if (resp_op !== 8'h00) $display("FAIL reset_resp_op got=%h want=00", resp_op); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", busy); else passed++;
    total++; if ({mem_reads, mem_writes, mem_errors} !== 36'd0)
      $display("FAIL reset_counters got=%h/%h/%h want=0/0/0", mem_reads, mem_writes, mem_errors); else passed++;
    reset = 1'b0;
    @(posedge clk); #1;
    total++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready got=%b want=1", req_ready); else passed++;
  endtask

  task automatic test_single_read;
    bit got; int cyc; logic [ADDR_W-1:0] a; logic [7:0] o;
    resp_ready = 1'b1;
    send(OP_READ, 48'h7fff493822b8, 1'b1);
    get_resp(20, got, cyc, a, o);
    total++; if (got !== 1'b1) $display("FAIL read_resp_seen got=%b want=1", got); else passed++;
    total++; if (cyc != LATENCY + 1) $display("FAIL read_latency got=%0d want=%0d", cyc, LATENCY + 1); else passed++;
    if (got && exp_addr_q.size() > 0) begin
      total++; if (a !== exp_addr_q[0]) $display("FAIL read_addr got=%h want=%h", a, exp_addr_q[0]); else passed++;
      total++; if (o !== exp_op_q[0]) $display("FAIL read_op got=%h want=%h", o, exp_op_q[0]); else passed++;
      void'(exp_addr_q.pop_front()); void'(exp_op_q.pop_front());
    end
    total++; if (mem_reads !== 12'(exp_reads)) $display("FAIL read_count got=%0d want=%0d", mem_reads, exp_reads); else passed++;
  endtask

  task automatic test_write;
    bit saw = 1'b0; logic [7:0] o = '0;
    resp_ready = 1'b1;
    send(OP_WRITE, 48'h0000006324d8, 1'b1);
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (resp_valid && !saw) begin saw = 1'b1; o = resp_op; end
    end
    total++; if (busy !== 1'b0) $display("FAIL write_busy_after6 got=%b want=0", busy); else passed++;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (resp_valid && !saw) begin saw = 1'b1; o = resp_op; end
    end
    total++; if (saw !== ACK_W) $display("FAIL write_resp_seen got=%b want=%b", saw, ACK_W); else passed++;
    if (saw && exp_op_q.size() > 0) begin
      total++; if (o !== exp_op_q[0]) $display("FAIL write_resp_op got=%h want=%h", o, exp_op_q[0]); else passed++;
      void'(exp_addr_q.pop_front()); void'(exp_op_q.pop_front());
    end
    total++; if (mem_writes !== 12'(exp_writes)) $display("FAIL write_count got=%0d want=%0d", mem_writes, exp_writes); else passed++;
  endtask

  task automatic test_illegal;
    bit any_busy = 1'b0, any_valid = 1'b0;
    resp_ready = 1'b1;
    send(8'h41, ADDR_W'({$urandom, $urandom}), 1'b1);
    for (int c = 0; c < 8; c++) begin
      if (busy) any_busy = 1'b1;
      if (resp_valid) any_valid = 1'b1;
      @(posedge clk); #1;
    end
    total++; if (any_busy !== 1'b0) $display("FAIL illegal_busy got=%b want=0", any_busy); else passed++;
    total++; if (any_valid !== 1'b0) $display("FAIL illegal_resp got=%b want=0", any_valid); else passed++;
    total++; if (mem_errors !== 12'(exp_errors)) $display("FAIL illegal_count got=%0d want=%0d", mem_errors, exp_errors); else passed++;
  endtask

  task automatic test_back_to_back;
    logic [ADDR_W-1:0] a6;
    bit stuck = 1'b1;
    int n = 0;
    bit acc, hs;
    resp_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(OP_READ, ADDR_W'({$urandom, $urandom}), 1'b1);
    total++; if (req_ready !== 1'b0) $display("FAIL b2b_full_ready got=%b want=0", req_ready); else passed++;
    a6 = ADDR_W'({$urandom, $urandom});
    req_valid = 1'b1; req_op = OP_READ; req_addr = a6;
    for (int c = 0; c < 6; c++) begin
      if (req_ready) stuck = 1'b0;
      @(posedge clk); #1;
    end
    total++; if (stuck !== 1'b1) $display("FAIL b2b_stall got=%b want=1", stuck); else passed++;
    total++; if (resp_valid !== 1'b1 || resp_addr !== exp_addr_q[0])
      $display("FAIL b2b_hold got=%b/%h want=1/%h", resp_valid, resp_addr, exp_addr_q[0]); else passed++;
    resp_ready = 1'b1;
    for (int c = 0; c < 300 && n < 6; c++) begin
      acc = req_valid && req_ready;
      hs  = resp_valid && resp_ready;
      if (hs) begin
        if (exp_addr_q.size() == 0) begin
          total++; $display("FAIL b2b_extra_resp got=%h want=none", resp_addr);
        end else begin
          total++; if (resp_addr !== exp_addr_q[0] || resp_op !== exp_op_q[0])
            $display("FAIL b2b_resp%0d got=%h/%h want=%h/%h", n, resp_addr, resp_op, exp_addr_q[0], exp_op_q[0]);
          else passed++;
          void'(exp_addr_q.pop_front()); void'(exp_op_q.pop_front());
        end
        n++;
      end
      @(posedge clk); #1;
      if (acc) begin
        req_valid = 1'b0;
        model_count(OP_READ);
        exp_addr_q.push_back(a6 & LINE_MASK);
        exp_op_q.push_back(OP_READ);
      end
    end
    req_valid = 1'b0;
    total++; if (n != 6) $display("FAIL b2b_resp_count got=%0d want=6", n); else passed++;
    total++; if (mem_reads !== 12'(exp_reads)) $display("FAIL b2b_read_count got=%0d want=%0d", mem_reads, exp_reads); else passed++;
  endtask

  task automatic test_reset_mid;
    bit got; int cyc; logic [ADDR_W-1:0] a; logic [7:0] o;
    bit any_valid = 1'b0;
    resp_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(OP_READ, ADDR_W'({$urandom, $urandom}), 1'b0);
    total++; if (busy !== 1'b1) $display("FAIL rmid_busy_before got=%b want=1", busy); else passed++;
    #2 reset = 1'b1;
    #1;
    exp_reads = 0; exp_writes = 0; exp_errors = 0;
    exp_addr_q.delete(); exp_op_q.delete();
    total++; if ({resp_valid, busy} !== 2'b00) $display("FAIL rmid_async_flags got=%b%b want=00", resp_valid, busy); else passed++;
    total++; if (mem_reads !== 12'd0) $display("FAIL rmid_async_count got=%0d want=0", mem_reads); else passed++;
    @(posedge clk); #1;
    reset = 1'b0;
    resp_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (resp_valid || busy) any_valid = 1'b1;
      @(posedge clk); #1;
    end
    total++; if (any_valid !== 1'b0) $display("FAIL rmid_no_resp got=%b want=0", any_valid); else passed++;
    send(OP_READ, 48'h123456789abc, 1'b1);
    get_resp(20, got, cyc, a, o);
    total++; if (got !== 1'b1 || cyc != LATENCY + 1) $display("FAIL rmid_next_read got=%b/%0d want=1/%0d", got, cyc, LATENCY + 1); else passed++;
    if (exp_addr_q.size() > 0) begin
      total++; if (a !== exp_addr_q[0]) $display("FAIL rmid_next_addr got=%h want=%h", a, exp_addr_q[0]); else passed++;
      void'(exp_addr_q.pop_front()); void'(exp_op_q.pop_front());
    end
    total++; if (mem_reads !== 12'(exp_reads)) $display("FAIL rmid_read_count got=%0d want=%0d", mem_reads, exp_reads); else passed++;
  endtask

  task automatic test_saturation;
    resp_ready = 1'b1;
    for (int i = 0; i < 4100; i++) begin
      send(OP_READ, ADDR_W'(i) << 6, 1'b0);
      if (i == 4000) begin
        total++; if (mem_reads !== 12'(exp_reads)) $display("FAIL sat_mid got=%0d want=%0d", mem_reads, exp_reads); else passed++;
      end
    end
    total++; if (mem_reads !== 12'(exp_reads)) $display("FAIL sat_hold got=%h want=%h", mem_reads, 12'(exp_reads)); else passed++;
    for (int c = 0; c < 200 && busy; c++) begin
      @(posedge clk); #1;
    end
    total++; if (busy !== 1'b0) $display("FAIL sat_drain got=%b want=0", busy); else passed++;
    total++; if (mem_reads !== 12'hFFF) $display("FAIL sat_final got=%h want=fff", mem_reads); else passed++;
  endtask

  initial begin
    test_reset;
    test_single_read;
    test_write;
    test_illegal;
    test_back_to_back;
    test_reset_mid;
    test_saturation;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
